// File: rtl/program_loader.sv
// UART boot loader: requests a program with a sync byte, receives a 32-bit byte count
// and the program words, writes them to instruction memory, then acknowledges.
module program_loader #(
    parameter int         ADDR_WIDTH = 9,
    parameter logic [7:0] SYNC_BYTE  = 8'h99,
    parameter logic [7:0] ACK_BYTE   = 8'haa
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_ready,
    input  logic [7:0]            rdata,
    input  logic                  ferr,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            sdata,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wd,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            fsm_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_SYNC = 3'd1,
        RECV_SIZE = 3'd2,
        RECV_PROG = 3'd3,
        SEND_ACK  = 3'd4,
        DONE      = 3'd5,
        ERR       = 3'd6
    } state_t;

    localparam logic [31:0]         MAX_BYTES = 32'd4 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] WORD_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state;
    state_t                state_next;
    logic [1:0]            byte_cnt;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [31:0]           size_q;
    logic [23:0]           word_q;
    logic [31:0]           size_next;
    logic [31:0]           word_next;
    logic                  rx_ok;
    logic                  rx_bad;
    logic                  last_write;

    // Receive handshake: a byte is consumed only on a cycle where rx_ready is high;
    // with ferr also high the byte is rejected and the load aborts.
    assign rx_ok     = rx_ready && !ferr;
    assign rx_bad    = rx_ready && ferr;
    assign size_next = {rdata, size_q[31:8]};
    assign word_next = {rdata, word_q};

    // word_cnt has already advanced past the word being written, so equality with
    // size/4 marks the final write cycle.
    assign last_write = imem_we && ({word_cnt, 2'b00} == size_q[ADDR_WIDTH+2:0]);

    assign fsm_state = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) state_next = SEND_SYNC;
            end
            SEND_SYNC: begin
                if (!tx_busy) state_next = RECV_SIZE;
            end
            RECV_SIZE: begin
                if (rx_bad) begin
                    state_next = ERR;
                end else if (rx_ok && byte_cnt == 2'd3) begin
                    if (size_next == 32'd0) begin
                        state_next = SEND_ACK;
                    end else if (size_next[1:0] != 2'b00 || size_next > MAX_BYTES) begin
                        state_next = ERR;
                    end else begin
                        state_next = RECV_PROG;
                    end
                end
            end
            RECV_PROG: begin
                if (last_write) begin
                    state_next = SEND_ACK;
                end else if (rx_bad) begin
                    state_next = ERR;
                end
            end
            SEND_ACK: begin
                if (!tx_busy) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_start = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            SEND_SYNC, SEND_ACK: begin
                tx_start = !tx_busy;
                busy     = 1'b1;
            end
            RECV_SIZE, RECV_PROG: busy  = 1'b1;
            DONE:                 done  = 1'b1;
            ERR:                  error = 1'b1;
            default: ;
        endcase
    end

    // sdata is loaded on entry to a send state so it is stable for the whole wait.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sdata     <= 8'h00;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_wd   <= 32'h0;
            byte_cnt  <= 2'd0;
            word_cnt  <= '0;
            size_q    <= 32'h0;
            word_q    <= 24'h0;
        end else begin
            imem_we <= 1'b0;
            if (state_next == SEND_SYNC && state != SEND_SYNC) sdata <= SYNC_BYTE;
            if (state_next == SEND_ACK && state != SEND_ACK) sdata <= ACK_BYTE;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        byte_cnt <= 2'd0;
                        word_cnt <= '0;
                    end
                end
                RECV_SIZE: begin
                    if (rx_ok) begin
                        size_q   <= size_next;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                RECV_PROG: begin
                    if (rx_ok && !last_write) begin
                        word_q   <= word_next[31:8];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            imem_we   <= 1'b1;
                            imem_wd   <= word_next;
                            imem_addr <= word_cnt[ADDR_WIDTH-1:0];
                            word_cnt  <= word_cnt + WORD_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized load sequences for program_loader, checked against a
// byte-stream reference model and a write/transmit scoreboard.
module tb_program_loader;

    localparam int         AW   = 9;
    localparam int         W    = AW + 32;
    localparam logic [7:0] SYNC = 8'h99;
    localparam logic [7:0] ACK  = 8'haa;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RECV_SIZE = 3'd2;
    localparam logic [2:0] ST_SEND_ACK  = 3'd4;

    logic          clock    = 1'b0;
    logic          reset    = 1'b1;
    logic          start    = 1'b0;
    logic          rx_ready = 1'b0;
    logic [7:0]    rdata    = 8'h00;
    logic          ferr     = 1'b0;
    logic          tx_busy  = 1'b0;
    logic          tx_start;
    logic [7:0]    sdata;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wd;
    logic          busy;
    logic          done;
    logic          error;
    logic [2:0]    fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [7:0]   tx_q[$];
    logic [7:0]   byte_q[$];
    logic         prev_tx = 1'b0;

    program_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(SYNC), .ACK_BYTE(ACK)) dut (
        .clock(clock), .reset(reset), .start(start), .rx_ready(rx_ready),
        .rdata(rdata), .ferr(ferr), .tx_busy(tx_busy), .tx_start(tx_start),
        .sdata(sdata), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
        .busy(busy), .done(done), .error(error), .fsm_state(fsm_state)
    );

    always #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard capture of writes and transmissions, sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset) begin
            if (imem_we) got_q.push_back({imem_addr, imem_wd});
            if (tx_start) begin
                check("tx_start_while_tx_busy", {63'd0, tx_busy}, 64'd0);
                check("tx_start_back_to_back", {63'd0, prev_tx}, 64'd0);
                tx_q.push_back(sdata);
            end
            prev_tx = tx_start;
        end else begin
            prev_tx = 1'b0;
        end
    end

    // Reference: byte_q holds the 4 size bytes then the program bytes; ferr_at is the
    // index of the byte carrying a framing error (-1 for none). Returns 1 for DONE.
    function automatic bit model(input logic [31:0] size, input int ferr_at);
        exp_q.delete();
        if (ferr_at >= 0 && ferr_at < 4) return 1'b0;
        if (size % 4 != 0 || size > 32'(4 * (1 << AW))) return 1'b0;
        for (int n = 0; n < int'(size / 4); n++) begin
            if (ferr_at >= 0 && ferr_at < 8 + 4 * n) return 1'b0;
            exp_q.push_back({AW'(n), byte_q[4+4*n+3], byte_q[4+4*n+2],
                             byte_q[4+4*n+1], byte_q[4+4*n]});
        end
        return 1'b1;
    endfunction

    task automatic build(input logic [31:0] size, input int nprog, input bit counter);
        logic [31:0] w;
        byte_q.delete();
        for (int i = 0; i < 4; i++) byte_q.push_back(size[8*i +: 8]);
        for (int i = 0; i < nprog; i++) begin
            if (counter) begin
                w = 32'h1000_0000 + 32'(i / 4);
                byte_q.push_back(w[8*(i%4) +: 8]);
            end else begin
                byte_q.push_back(8'($urandom));
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe, input logic st);
        rx_ready = 1'b1;
        rdata    = b;
        ferr     = fe;
        start    = st;
        step();
        rx_ready = 1'b0;
        ferr     = 1'b0;
        start    = 1'b0;
        rdata    = 8'($urandom);
        repeat ($urandom_range(1, 2)) step();
    endtask

    task automatic begin_load(input string tag);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_sync_tx_start"}, {63'd0, tx_start}, 64'd1);
        check({tag, "_sync_sdata"}, {56'd0, sdata}, {56'd0, SYNC});
        check({tag, "_busy_after_start"}, {63'd0, busy}, 64'd1);
        step();
        check({tag, "_state_recv_size"}, {61'd0, fsm_state}, {61'd0, ST_RECV_SIZE});
    endtask

    task automatic run_case(input string tag, input logic [31:0] size, input int ferr_at,
                            input bit hold_ack, input bit poke_start);
        bit exp_done;
        int nsend;
        bit seen;
        int k;
        exp_done = model(size, ferr_at);
        got_q.delete();
        tx_q.delete();
        nsend = (ferr_at >= 0) ? ferr_at + 1 : byte_q.size();
        begin_load(tag);
        for (int i = 0; i < nsend; i++) begin
            if (hold_ack && i == nsend - 1) tx_busy = 1'b1;
            send_byte(byte_q[i], (i == ferr_at), (poke_start && i == 10));
        end
        if (hold_ack && exp_done) begin
            k = 0;
            while (k < 20 && fsm_state !== ST_SEND_ACK) begin
                step();
                k++;
            end
            check({tag, "_reached_send_ack"}, {61'd0, fsm_state}, {61'd0, ST_SEND_ACK});
            seen = 1'b0;
            repeat (50) begin
                step();
                if (tx_start) seen = 1'b1;
            end
            check({tag, "_no_ack_while_busy"}, {63'd0, seen}, 64'd0);
            tx_busy = 1'b0;
            #1;
            check({tag, "_ack_after_busy_falls"}, {63'd0, tx_start}, 64'd1);
            check({tag, "_ack_sdata"}, {56'd0, sdata}, {56'd0, ACK});
        end
        tx_busy = 1'b0;
        k = 0;
        while (k < 100 && !(done || error)) begin
            step();
            k++;
        end
        check({tag, "_done"}, {63'd0, done}, {63'd0, exp_done});
        check({tag, "_error"}, {63'd0, error}, {63'd0, !exp_done});
        check({tag, "_busy_cleared"}, {63'd0, busy}, 64'd0);
        check({tag, "_write_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) check({tag, "_write_entry"}, 64'(got_q[i]), 64'(exp_q[i]));
        end
        if (exp_q.size() > 0) begin
            check({tag, "_addr_holds"}, 64'(imem_addr), 64'(exp_q.size() - 1));
        end
        check({tag, "_tx_count"}, 64'(tx_q.size()), exp_done ? 64'd2 : 64'd1);
        if (tx_q.size() > 0) check({tag, "_tx0"}, {56'd0, tx_q[0]}, {56'd0, SYNC});
        if (exp_done && tx_q.size() > 1) check({tag, "_tx1"}, {56'd0, tx_q[1]}, {56'd0, ACK});
    endtask

    initial begin
        logic [31:0] rsize;

        // Reset state
        repeat (3) step();
        check("rst_tx_start", {63'd0, tx_start}, 64'd0);
        check("rst_sdata", {56'd0, sdata}, 64'd0);
        check("rst_imem_we", {63'd0, imem_we}, 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_imem_wd", {32'd0, imem_wd}, 64'd0);
        check("rst_busy_done_error", {61'd0, busy, done, error}, 64'd0);
        check("rst_state", {61'd0, fsm_state}, {61'd0, ST_IDLE});
        reset = 1'b0;
        step();

        // Stray receive byte in IDLE is ignored
        send_byte(8'h55, 1'b0, 1'b0);
        check("idle_ignores_rx", {61'd0, fsm_state}, {61'd0, ST_IDLE});

        // 240-byte counter program, with a start pulse mid-load that must be ignored
        build(32'd240, 240, 1'b1);
        run_case("prog240", 32'd240, -1, 1'b0, 1'b1);

        build(32'd0, 0, 1'b0);
        run_case("size0", 32'd0, -1, 1'b0, 1'b0);

        build(32'd6, 0, 1'b0);
        run_case("size6", 32'd6, -1, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0);
        check("err_ignores_rx", {63'd0, error}, 64'd1);

        build(32'h804, 0, 1'b0);
        run_case("size804", 32'h804, -1, 1'b0, 1'b0);

        build(32'd32, 32, 1'b0);
        run_case("ferr_w5", 32'd32, 4 + 22, 1'b0, 1'b0);

        build(32'd16, 0, 1'b0);
        run_case("ferr_size", 32'd16, 2, 1'b0, 1'b0);

        rsize = 32'(4 * $urandom_range(1, 8));
        build(rsize, int'(rsize), 1'b0);
        run_case("ack_hold", rsize, -1, 1'b1, 1'b0);

        for (int t = 0; t < 3; t++) begin
            rsize = 32'(4 * $urandom_range(1, 24));
            build(rsize, int'(rsize), 1'b0);
            if (t == 2) run_case("rand_ferr", rsize, $urandom_range(4, int'(rsize) + 3), 1'b0, 1'b0);
            else run_case("rand_load", rsize, -1, 1'b0, 1'b0);
        end

        build(32'd2048, 2048, 1'b0);
        run_case("size_max", 32'd2048, -1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of program reception
        build(32'd64, 64, 1'b0);
        got_q.delete();
        tx_q.delete();
        begin_load("rst_mid");
        for (int i = 0; i < 14; i++) send_byte(byte_q[i], 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("rst_mid_outputs", {tx_start, sdata, imem_we, 32'(imem_addr), imem_wd[15:0], busy, done, error},
              64'd0);
        check("rst_mid_wd_hi", {48'd0, imem_wd[31:16]}, 64'd0);
        check("rst_mid_state", {61'd0, fsm_state}, {61'd0, ST_IDLE});
        step();
        step();
        reset = 1'b0;
        for (int i = 14; i < 22; i++) send_byte(byte_q[i], 1'b0, 1'b0);
        repeat (5) step();
        void'(model(32'd8, -1));
        check("rst_mid_write_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check("rst_mid_write_entry", 64'(got_q[i]), 64'(exp_q[i]));
        end
        check("rst_mid_tx_count", 64'(tx_q.size()), 64'd1);
        check("rst_mid_idle", {61'd0, fsm_state}, {61'd0, ST_IDLE});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The parameter ADDR_WIDTH SHALL default to 9 and set the instruction-memory word-address width (2^ADDR_WIDTH words).
REQ-002 The parameter SYNC_BYTE SHALL default to 8'h99 and set the byte sent to request a program.
REQ-003 The parameter ACK_BYTE SHALL default to 8'haa and set the byte sent after the last program word.
REQ-004 The port clock SHALL be an input of width 1 and be the single clock; all state SHALL be updated on posedge clock.
REQ-005 The port reset SHALL be an input of width 1 and be the asynchronous, active-high reset.
REQ-006 The port start SHALL be an input of width 1; a one-cycle pulse begins a load sequence.
REQ-007 The port rx_ready SHALL be an input of width 1; a one-cycle pulse means rdata is valid.
REQ-008 The port rdata SHALL be an 8-bit input carrying the byte received from the UART receiver.
REQ-009 The port ferr SHALL be a 1-bit input carrying the UART receiver framing error, sampled with rx_ready.
REQ-010 The port tx_busy SHALL be a 1-bit input that is high while the UART transmitter is sending.
REQ-011 The port tx_start SHALL be a 1-bit output; a one-cycle pulse launches transmission of sdata.
REQ-012 The port sdata SHALL be an 8-bit output carrying the byte to transmit.
REQ-013 The port imem_we SHALL be a 1-bit output: the instruction-memory write strobe.
REQ-014 The port imem_addr SHALL be an ADDR_WIDTH-bit output: the instruction-memory word address.
REQ-015 The port imem_wd SHALL be a 32-bit output: the instruction-memory write data.
REQ-016 The port busy SHALL be a 1-bit output that is high from start acceptance until DONE or ERR.
REQ-017 The port done SHALL be a 1-bit output that is held high in DONE.
REQ-018 The port error SHALL be a 1-bit output that is held high in ERR.

Function
REQ-019 The states SHALL be IDLE, SEND_SYNC, RECV_SIZE, RECV_PROG, SEND_ACK, DONE and ERR.
REQ-020 In IDLE, DONE or ERR, a start pulse SHALL clear the byte counters and word counter and move to SEND_SYNC.
REQ-021 In SEND_SYNC or SEND_ACK with tx_busy low, tx_start SHALL pulse for exactly one cycle with sdata = SYNC_BYTE or ACK_BYTE respectively, and the block SHALL leave the state on that same edge.
REQ-022 SEND_SYNC SHALL go to RECV_SIZE; SEND_ACK SHALL go to DONE.
REQ-023 tx_start SHALL never be asserted while tx_busy is high, and SHALL never be asserted in two consecutive cycles.
REQ-024 RECV_SIZE SHALL accept four rx_ready bytes, least-significant byte first, into a 32-bit size register.
REQ-025 After the fourth size byte: size == 0 SHALL go to SEND_ACK; size[1:0] != 0 or size > 4*2^ADDR_WIDTH SHALL go to ERR; otherwise the block SHALL go to RECV_PROG.
REQ-026 RECV_PROG SHALL assemble bytes little-endian into a 32-bit word (first byte = bits 7:0).
REQ-027 On every fourth byte, imem_we SHALL pulse high for one cycle on the following cycle, with imem_wd = the assembled word and imem_addr = the word index, starting at 0.
REQ-028 After the write of word index size/4-1, the block SHALL enter SEND_ACK on the same edge that drops imem_we.
REQ-029 imem_addr SHALL hold its last value when imem_we is low; imem_we SHALL be low in all states except the write cycle.
REQ-030 An rx_ready pulse with ferr high in RECV_SIZE or RECV_PROG SHALL go to ERR, and no write SHALL occur for the partial word.
REQ-031 rx_ready pulses in IDLE, SEND_SYNC, SEND_ACK, DONE and ERR SHALL be ignored.
REQ-032 A start pulse in any other state SHALL be ignored.
REQ-033 The byte counter SHALL be 2 bits wide and wrap 3->0; the word counter SHALL be ADDR_WIDTH+1 bits wide and never wrap within a legal size.

Reset
REQ-034 While reset is high, the block SHALL be in IDLE with tx_start=0, sdata=0, imem_we=0, imem_addr=0, imem_wd=0, busy=0, done=0, error=0, and all counters and the size register at 0.
REQ-035 Reset asserted mid-load SHALL abort the load immediately, with no further imem_we or tx_start.

Verification
REQ-036 A bench SHALL drive start, tx_busy=0 -> require tx_start pulse with sdata=8'h99 within 1 cycle, then state RECV_SIZE.
REQ-037 A bench SHALL drive size bytes F0 00 00 00, then 240 program bytes where word n = 32'h1000_0000+n -> require 60 writes, addr 0..59, correct data, then sdata=8'haa, then done=1.
REQ-038 A bench SHALL drive size bytes 00 00 00 00 -> require no imem_we, tx_start with 8'haa, and done=1.
REQ-039 A bench SHALL drive size 0x00000006, and separately size 0x00000804 -> require error=1 and no imem_we.
REQ-040 A bench SHALL drive ferr=1 on byte 3 of word 5 -> require exactly 5 writes, then error=1.
REQ-041 A bench SHALL hold tx_busy=1 for 50 cycles on entry to SEND_ACK -> require no tx_start until the cycle after tx_busy falls; a reset asserted mid-RECV_PROG SHALL give all outputs 0 asynchronously.
